// File: rtl/merge_sort_ctrl_pkg.sv
// Shared types for the merge-sort ping-pong controller: FSM encodings and default widths.
package merge_sort_ctrl_pkg;

    localparam int unsigned CountWidthDefault = 16;

    // Top-level run sequencer; READY is the one-cycle ap_ready beat before RUN/FINISH.
    typedef enum logic [1:0] {
        TOP_IDLE   = 2'd0,
        TOP_READY  = 2'd1,
        TOP_RUN    = 2'd2,
        TOP_FINISH = 2'd3
    } top_state_t;

    // Producer and consumer sides share one encoding; STROBE is commit or release.
    typedef enum logic [1:0] {
        SIDE_WAIT   = 2'd0,
        SIDE_RUN    = 2'd1,
        SIDE_STROBE = 2'd2,
        SIDE_END    = 2'd3
    } side_state_t;

    typedef side_state_t prod_state_t;
    typedef side_state_t cons_state_t;

endpackage

// File: rtl/merge_sort_pingpong_ctrl_if.sv
// Handshake bundle between the ping-pong scheduler and the ap_ctrl, producer, consumer and buffer.
interface merge_sort_pingpong_ctrl_if #(
    parameter int unsigned CountWidth = merge_sort_ctrl_pkg::CountWidthDefault
);

    logic                  ap_start;
    logic [CountWidth-1:0] num_blocks;
    logic                  ap_ready;
    logic                  ap_idle;
    logic                  ap_done;
    logic                  prod_start;
    logic                  prod_done;
    logic                  cons_start;
    logic                  cons_done;
    logic                  i_ce;
    logic                  i_write;
    logic                  i_full_n;
    logic                  t_ce;
    logic                  t_read;
    logic                  t_empty_n;

    // Scheduler side.
    modport master (
        input  ap_start, num_blocks, prod_done, cons_done, i_full_n, t_empty_n,
        output ap_ready, ap_idle, ap_done, prod_start, cons_start,
               i_ce, i_write, t_ce, t_read
    );

    // Environment side: top-level control, processes and buffer.
    modport slave (
        output ap_start, num_blocks, prod_done, cons_done, i_full_n, t_empty_n,
        input  ap_ready, ap_idle, ap_done, prod_start, cons_start,
               i_ce, i_write, t_ce, t_read
    );

endinterface

// File: rtl/merge_sort_pingpong_side.sv
// One side of the ping-pong channel: waits for buffer space/data, runs a process, strobes
// the buffer and counts blocks. Instantiated once as producer and once as consumer.
module merge_sort_pingpong_side
    import merge_sort_ctrl_pkg::*;
#(
    parameter int unsigned CountWidth = CountWidthDefault
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [CountWidth-1:0] target,
    input  logic                  avail,
    input  logic                  done,
    output logic                  start,
    output logic                  strobe,
    output logic [CountWidth-1:0] cnt
);

    side_state_t           state_q;
    side_state_t           state_nx;
    logic                  start_q;
    logic                  strobe_q;
    logic [CountWidth-1:0] cnt_q;

    // State, registered outputs and block counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SIDE_WAIT;
            start_q  <= 1'b0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_nx;
            start_q  <= (state_nx == SIDE_RUN);
            strobe_q <= (state_nx == SIDE_STROBE);
            if (clear) begin
                cnt_q <= '0;
            end else if (state_q == SIDE_STROBE) begin
                cnt_q <= cnt_q + CountWidth'(1);
            end
        end
    end

    // Next state; a done pulse outside RUN is ignored.
    always_comb begin
        state_nx = state_q;
        if (!enable) begin
            state_nx = SIDE_WAIT;
        end else begin
            case (state_q)
                SIDE_WAIT: begin
                    if (cnt_q == target) begin
                        state_nx = SIDE_END;
                    end else if (avail) begin
                        state_nx = SIDE_RUN;
                    end
                end
                SIDE_RUN: begin
                    if (done) begin
                        state_nx = SIDE_STROBE;
                    end
                end
                SIDE_STROBE: state_nx = SIDE_WAIT;
                SIDE_END:    state_nx = SIDE_END;
                default:     state_nx = SIDE_WAIT;
            endcase
        end
    end

    assign start  = start_q;
    assign strobe = strobe_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/merge_sort_pingpong_ctrl.sv
// Block-level scheduler overlapping producer block N+1 with consumer block N through a
// ping-pong buffer; owns the ap_ctrl handshake and the per-run block count.
module merge_sort_pingpong_ctrl
    import merge_sort_ctrl_pkg::*;
#(
    parameter int unsigned CountWidth  = CountWidthDefault,
    parameter int unsigned BufferCount = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    merge_sort_pingpong_ctrl_if.master  ctrl
);

    top_state_t            state_q;
    top_state_t            state_nx;
    logic [CountWidth-1:0] n_q;
    logic [CountWidth-1:0] n_nx;
    logic                  ap_idle_q;
    logic                  ap_ready_q;
    logic                  ap_done_q;

    logic                  run_en;
    logic                  cnt_clear;
    logic                  prod_start;
    logic                  cons_start;
    logic                  commit;
    logic                  release_blk;
    logic [CountWidth-1:0] prod_cnt;
    logic [CountWidth-1:0] cons_cnt;

    // Top state, latched block count and registered ap_ctrl outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= TOP_IDLE;
            n_q        <= '0;
            ap_idle_q  <= 1'b1;
            ap_ready_q <= 1'b0;
            ap_done_q  <= 1'b0;
        end else begin
            state_q    <= state_nx;
            n_q        <= n_nx;
            ap_idle_q  <= (state_nx == TOP_IDLE);
            ap_ready_q <= (state_nx == TOP_READY);
            ap_done_q  <= (state_nx == TOP_FINISH);
        end
    end

    // Next state; ap_start only matters in IDLE.
    always_comb begin
        state_nx = state_q;
        n_nx     = n_q;
        case (state_q)
            TOP_IDLE: begin
                if (ctrl.ap_start) begin
                    state_nx = TOP_READY;
                    n_nx     = ctrl.num_blocks;
                end
            end
            TOP_READY: begin
                state_nx = (n_q == '0) ? TOP_FINISH : TOP_RUN;
            end
            TOP_RUN: begin
                if (cons_cnt == n_q) begin
                    state_nx = TOP_FINISH;
                end
            end
            TOP_FINISH: state_nx = TOP_IDLE;
            default:    state_nx = TOP_IDLE;
        endcase
    end

    assign run_en    = (state_q == TOP_RUN);
    assign cnt_clear = (state_q == TOP_READY);

    merge_sort_pingpong_side #(
        .CountWidth (CountWidth)
    ) u_prod (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (run_en),
        .clear   (cnt_clear),
        .target  (n_q),
        .avail   (ctrl.i_full_n),
        .done    (ctrl.prod_done),
        .start   (prod_start),
        .strobe  (commit),
        .cnt     (prod_cnt)
    );

    merge_sort_pingpong_side #(
        .CountWidth (CountWidth)
    ) u_cons (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (run_en),
        .clear   (cnt_clear),
        .target  (n_q),
        .avail   (ctrl.t_empty_n),
        .done    (ctrl.cons_done),
        .start   (cons_start),
        .strobe  (release_blk),
        .cnt     (cons_cnt)
    );

    // Committed-but-unreleased blocks can never exceed the buffer depth.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert ((prod_cnt - cons_cnt) <= CountWidth'(BufferCount));
        end
    end

    assign ctrl.ap_idle    = ap_idle_q;
    assign ctrl.ap_ready   = ap_ready_q;
    assign ctrl.ap_done    = ap_done_q;
    assign ctrl.prod_start = prod_start;
    assign ctrl.cons_start = cons_start;
    assign ctrl.i_ce       = commit;
    assign ctrl.i_write    = commit;
    assign ctrl.t_ce       = release_blk;
    assign ctrl.t_read     = release_blk;

endmodule

// File: tb/tb_merge_sort_pingpong_ctrl.sv
// Directed bench for merge_sort_pingpong_ctrl with a 2-slot buffer model and
// fixed-latency producer/consumer responders.
module tb_merge_sort_pingpong_ctrl;

    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    merge_sort_pingpong_ctrl_if #(.CountWidth(CW)) bus ();

    merge_sort_pingpong_ctrl #(
        .CountWidth  (CW),
        .BufferCount (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctrl    (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   occ;
    int   prod_lat;
    int   cons_lat;
    logic prod_auto;
    logic cons_auto;
    logic prod_spur;
    logic hit;

    int cyc, n_commit, n_release, n_done, n_ready, n_both, n_start;
    int n_viol, n_stall, n_pair_err, max_occ, last_rel_cyc, done_cyc;

    // Two-slot buffer: commit adds, release removes, both in one cycle nets to zero.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) occ <= 0;
        else          occ <= occ + int'(bus.i_write) - int'(bus.t_read);
    end

    assign bus.i_full_n  = (occ < 2);
    assign bus.t_empty_n = (occ > 0);
    assign bus.prod_done = prod_auto | prod_spur;
    assign bus.cons_done = cons_auto;

    initial begin : prod_resp
        int p;
        p = 0;
        prod_auto = 1'b0;
        forever begin
            @(negedge clk);
            prod_auto = 1'b0;
            if (bus.prod_start === 1'b1) begin
                p++;
                if (p >= prod_lat) begin
                    prod_auto = 1'b1;
                    p = 0;
                end
            end else begin
                p = 0;
            end
        end
    end

    initial begin : cons_resp
        int c;
        c = 0;
        cons_auto = 1'b0;
        forever begin
            @(negedge clk);
            cons_auto = 1'b0;
            if (bus.cons_start === 1'b1) begin
                c++;
                if (c >= cons_lat) begin
                    cons_auto = 1'b1;
                    c = 0;
                end
            end else begin
                c = 0;
            end
        end
    end

    // Per-cycle activity counters, sampled just after each rising edge.
    initial begin : monitor
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.i_write === 1'b1) n_commit++;
            if (bus.t_read === 1'b1) begin
                n_release++;
                last_rel_cyc = cyc;
            end
            if (bus.ap_done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.ap_ready === 1'b1) n_ready++;
            if (bus.i_write === 1'b1 && bus.t_read === 1'b1) n_both++;
            if (bus.prod_start === 1'b1 || bus.cons_start === 1'b1) n_start++;
            if (bus.prod_start === 1'b1 && bus.i_full_n === 1'b0) n_viol++;
            if (bus.i_full_n === 1'b0) n_stall++;
            if (bus.i_ce !== bus.i_write || bus.t_ce !== bus.t_read) n_pair_err++;
            if (occ > max_occ) max_occ = occ;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_commit = 0; n_release = 0; n_done = 0; n_ready = 0; n_both = 0;
        n_start = 0; n_viol = 0; n_stall = 0; n_pair_err = 0; max_occ = 0;
        last_rel_cyc = 0; done_cyc = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic start_run(input logic [CW-1:0] n);
        bus.num_blocks = n;
        bus.ap_start   = 1'b1;
        @(negedge clk);
        bus.ap_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.ap_done === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.ap_start   = 1'b0;
        bus.num_blocks = '0;
        prod_spur      = 1'b0;
        prod_lat       = 3;
        cons_lat       = 3;
        clear_stats();
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_ap_idle",    32'(bus.ap_idle),    1);
        check("rst_ap_ready",   32'(bus.ap_ready),   0);
        check("rst_ap_done",    32'(bus.ap_done),    0);
        check("rst_prod_start", 32'(bus.prod_start), 0);
        check("rst_cons_start", 32'(bus.cons_start), 0);
        check("rst_i_write",    32'(bus.i_write),    0);
        check("rst_t_read",     32'(bus.t_read),     0);
        reset_n = 1'b1;
        @(negedge clk);

        // N=1, producer 5 cycles, consumer 4 cycles.
        prod_lat = 5; cons_lat = 4;
        clear_stats();
        start_run(16'd1);
        check("n1_ready_e0",      32'(bus.ap_ready),   1);
        check("n1_idle_e0",       32'(bus.ap_idle),    0);
        @(negedge clk);
        check("n1_ready_e1",      32'(bus.ap_ready),   0);
        check("n1_prod_start_e1", 32'(bus.prod_start), 0);
        @(negedge clk);
        check("n1_prod_start_e2", 32'(bus.prod_start), 1);
        wait_done(200, hit);
        check("n1_done_seen",     32'(hit),            1);
        @(negedge clk);
        check("n1_done_pulse",    32'(bus.ap_done),    0);
        check("n1_idle_back",     32'(bus.ap_idle),    1);
        check("n1_commits",       32'(n_commit),       1);
        check("n1_releases",      32'(n_release),      1);
        check("n1_done_count",    32'(n_done),         1);
        check("n1_full_n",        32'(bus.i_full_n),   1);
        check("n1_empty_n",       32'(bus.t_empty_n),  0);
        check("n1_done_latency",  32'(done_cyc - last_rel_cyc), 2);
        check("n1_strobe_pairs",  32'(n_pair_err),     0);

        // N=4, fast producer, slow consumer: producer must stall on a full buffer.
        prod_lat = 3; cons_lat = 20;
        clear_stats();
        start_run(16'd4);
        wait_done(400, hit);
        check("slow_done_seen",   32'(hit),            1);
        @(negedge clk);
        check("slow_commits",     32'(n_commit),       4);
        check("slow_releases",    32'(n_release),      4);
        check("slow_done_count",  32'(n_done),         1);
        check("slow_start_full",  32'(n_viol),         0);
        check("slow_stalled",     32'(n_stall > 0),    1);
        check("slow_max_occ",     32'(max_occ),        2);
        check("slow_empty_n",     32'(bus.t_empty_n),  0);

        // N=4, equal latencies: commit and release land together three times.
        prod_lat = 6; cons_lat = 6;
        clear_stats();
        start_run(16'd4);
        wait_done(400, hit);
        check("pair_done_seen",   32'(hit),            1);
        @(negedge clk);
        check("pair_commits",     32'(n_commit),       4);
        check("pair_releases",    32'(n_release),      4);
        check("pair_both",        32'(n_both),         3);
        check("pair_max_occ",     32'(max_occ),        1);
        check("pair_done_count",  32'(n_done),         1);
        check("pair_strobe_pairs",32'(n_pair_err),     0);

        // N=0: ap_done directly follows ap_ready.
        clear_stats();
        start_run(16'd0);
        check("n0_ready_e0",      32'(bus.ap_ready),   1);
        check("n0_done_e0",       32'(bus.ap_done),    0);
        @(negedge clk);
        check("n0_ready_e1",      32'(bus.ap_ready),   0);
        check("n0_done_e1",       32'(bus.ap_done),    1);
        @(negedge clk);
        check("n0_done_e2",       32'(bus.ap_done),    0);
        check("n0_idle_e2",       32'(bus.ap_idle),    1);
        check("n0_no_starts",     32'(n_start),        0);
        check("n0_no_commits",    32'(n_commit),       0);

        // Spurious prod_done in P_WAIT and a second ap_start during RUN.
        prod_lat = 4; cons_lat = 4;
        clear_stats();
        start_run(16'd2);
        @(negedge clk);
        prod_spur = 1'b1;
        @(negedge clk);
        prod_spur = 1'b0;
        check("spur_prod_start",  32'(bus.prod_start), 1);
        check("spur_no_commit",   32'(bus.i_write),    0);
        bus.num_blocks = 16'd7;
        bus.ap_start   = 1'b1;
        @(negedge clk);
        bus.ap_start   = 1'b0;
        check("spur_ready_run",   32'(bus.ap_ready),   0);
        wait_done(300, hit);
        check("spur_done_seen",   32'(hit),            1);
        @(negedge clk);
        check("spur_commits",     32'(n_commit),       2);
        check("spur_releases",    32'(n_release),      2);
        check("spur_ready_count", 32'(n_ready),        1);
        check("spur_done_count",  32'(n_done),         1);
        check("spur_idle",        32'(bus.ap_idle),    1);

        // Reset in the middle of a run.
        prod_lat = 3; cons_lat = 20;
        clear_stats();
        start_run(16'd4);
        repeat (30) @(negedge clk);
        check("mid_prod_cnt_live", 32'(dut.prod_cnt != '0), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_idle",     32'(bus.ap_idle),    1);
        check("mid_rst_prod",     32'(bus.prod_start), 0);
        check("mid_rst_cons",     32'(bus.cons_start), 0);
        check("mid_rst_i_write",  32'(bus.i_write),    0);
        check("mid_rst_t_read",   32'(bus.t_read),     0);
        check("mid_rst_prod_cnt", 32'(dut.prod_cnt),   0);
        check("mid_rst_cons_cnt", 32'(dut.cons_cnt),   0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Clean run after the mid-run reset.
        prod_lat = 2; cons_lat = 2;
        clear_stats();
        start_run(16'd2);
        wait_done(200, hit);
        check("post_done_seen",   32'(hit),            1);
        @(negedge clk);
        check("post_commits",     32'(n_commit),       2);
        check("post_releases",    32'(n_release),      2);
        check("post_done_count",  32'(n_done),         1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
